// File: rtl/logic_pkg.sv
// Shared op codes for the NAND-derived logic unit.
// Imported by the core and the pipe wrapper.
package logic_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NAND,
      OP_AND,
      OP_OR,
      OP_NOR,
      OP_XOR,
      OP_XNOR,
      OP_NOT_A,
      OP_PASS_A
   } op_e;

endpackage

// File: rtl/_Nand.sv
// 1-bit NAND primitive.
// Every logic op in the unit is built from this cell.
module _Nand (
   input  logic a,
   input  logic b,
   output logic out
);

   assign out = ~(a & b);

endmodule

// File: rtl/nand_logic_core.sv
// Combinational WIDTH-bit logic unit built from NAND cells.
// Produces result plus zero/negative flags.
module nand_logic_core
   import logic_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   output logic [WIDTH-1:0] res,
   output logic             zr,
   output logic             ng
);

   logic [WIDTH-1:0] nand_v;
   logic [WIDTH-1:0] and_v;
   logic [WIDTH-1:0] or_v;
   logic [WIDTH-1:0] nor_v;
   logic [WIDTH-1:0] xor_v;
   logic [WIDTH-1:0] xnor_v;
   logic [WIDTH-1:0] nota_v;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic n_ab;
      logic n_aa;
      logic n_bb;
      logic t_a;
      logic t_b;
      logic x_ab;
      logic o_ab;

      _Nand u_ab (.a(a[i]), .b(b[i]), .out(n_ab));
      _Nand u_aa (.a(a[i]), .b(a[i]), .out(n_aa));
      _Nand u_bb (.a(b[i]), .b(b[i]), .out(n_bb));
      _Nand u_an (.a(n_ab), .b(n_ab), .out(and_v[i]));
      _Nand u_or (.a(n_aa), .b(n_bb), .out(o_ab));
      _Nand u_nr (.a(o_ab), .b(o_ab), .out(nor_v[i]));
      // classic four-NAND XOR
      _Nand u_ta (.a(a[i]), .b(n_ab), .out(t_a));
      _Nand u_tb (.a(b[i]), .b(n_ab), .out(t_b));
      _Nand u_xo (.a(t_a), .b(t_b), .out(x_ab));
      _Nand u_xn (.a(x_ab), .b(x_ab), .out(xnor_v[i]));

      assign nand_v[i] = n_ab;
      assign or_v[i]   = o_ab;
      assign xor_v[i]  = x_ab;
      assign nota_v[i] = n_aa;
   end

   always_comb begin
      res = '0;
      unique case (op)
         OP_NAND:   res = nand_v;
         OP_AND:    res = and_v;
         OP_OR:     res = or_v;
         OP_NOR:    res = nor_v;
         OP_XOR:    res = xor_v;
         OP_XNOR:   res = xnor_v;
         OP_NOT_A:  res = nota_v;
         OP_PASS_A: res = a;
         default:   res = '0;
      endcase
   end

   assign zr = (res == '0);
   assign ng = res[WIDTH-1];

endmodule

// File: rtl/nand_logic_pipe.sv
// Registered NAND logic unit with valid/ready handshake.
// Two-entry in-order result buffer absorbs backpressure.
module nand_logic_pipe
   import logic_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng
);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             zr;
      logic             ng;
   } ent_t;

   ent_t       head;
   ent_t       tail;
   ent_t       nxt;
   logic [1:0] count;
   logic       push;
   logic       pop;

   logic [WIDTH-1:0] c_res;
   logic             c_zr;
   logic             c_ng;

   nand_logic_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .a  (a),
      .b  (b),
      .op (op),
      .res(c_res),
      .zr (c_zr),
      .ng (c_ng)
   );

   assign nxt = '{res: c_res, zr: c_zr, ng: c_ng};

   // registered count only, so out_ready never reaches in_ready
   assign in_ready  = rst_n && (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         unique case (1'b1)
            push && !pop: begin
               if (count == 2'd0) head <= nxt;
               else               tail <= nxt;
               count <= count + 2'd1;
            end
            pop && !push: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            push && pop: head <= nxt;
            default: ;
         endcase
      end
   end

   assign out = head.res;
   assign zr  = head.zr;
   assign ng  = head.ng;

endmodule
